// File: rtl/mem_reg_xfer_ctrl.sv
// Command sequencer driving the data memory and register-file ports.
// Each accepted command runs as a fixed READ/WAIT/WRITE strobe sequence.
module mem_reg_xfer_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_mem_addr,
    input  logic [ADDR_W-1:0] cmd_reg_src,
    input  logic [ADDR_W-1:0] cmd_reg_dst,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] reg_raddr,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic [ADDR_W-1:0] reg_waddr,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              done,
    output logic              busy,
    output logic [CNT_W-1:0]  xfer_count
);

    typedef enum logic [1:0] {StIdle, StRead, StWait, StWrite} state_e;

    localparam logic [1:0] OpWriteI = 2'b00;
    localparam logic [1:0] OpLoad   = 2'b01;
    localparam logic [1:0] OpStore  = 2'b10;

    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   maddr_q, maddr_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_re_q, mem_re_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0]   reg_raddr_q, reg_raddr_d;
    logic                reg_re_q, reg_re_d;
    logic [ADDR_W-1:0]   reg_waddr_q, reg_waddr_d;
    logic                reg_we_q, reg_we_d;
    logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    cnt_inc;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    // Outputs are registered, so each branch computes the values for the state being entered.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        maddr_d     = maddr_q;
        dst_d       = dst_q;
        cmd_ready_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        reg_raddr_d = reg_raddr_q;
        reg_re_d    = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_we_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        done_d      = 1'b0;
        busy_d      = 1'b1;
        cnt_d       = cnt_q;

        case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    maddr_d     = cmd_mem_addr;
                    dst_d       = cmd_reg_dst;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (cmd_op == OpWriteI) begin
                        state_d     = StWrite;
                        reg_we_d    = 1'b1;
                        reg_waddr_d = cmd_reg_dst;
                        reg_wdata_d = cmd_data;
                        done_d      = 1'b1;
                        cnt_d       = cnt_inc;
                    end else begin
                        state_d = StRead;
                        if (cmd_op == OpLoad) begin
                            mem_re_d   = 1'b1;
                            mem_addr_d = cmd_mem_addr;
                        end else begin
                            reg_re_d    = 1'b1;
                            reg_raddr_d = cmd_reg_src;
                        end
                    end
                end
            end
            StRead: state_d = StWait;
            StWait: begin
                // Read data arrives this cycle; it is captured straight into the write-data register.
                state_d = StWrite;
                done_d  = 1'b1;
                cnt_d   = cnt_inc;
                if (op_q == OpStore) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = maddr_q;
                    mem_wdata_d = reg_rdata;
                end else begin
                    reg_we_d    = 1'b1;
                    reg_waddr_d = dst_q;
                    reg_wdata_d = (op_q == OpLoad) ? mem_rdata : reg_rdata;
                end
            end
            StWrite: begin
                state_d     = StIdle;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            maddr_q     <= '0;
            dst_q       <= '0;
            // Reset lands in IDLE, so the controller is ready as soon as reset releases.
            cmd_ready_q <= 1'b1;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            reg_raddr_q <= '0;
            reg_re_q    <= 1'b0;
            reg_waddr_q <= '0;
            reg_we_q    <= 1'b0;
            reg_wdata_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            maddr_q     <= maddr_d;
            dst_q       <= dst_d;
            cmd_ready_q <= cmd_ready_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            reg_raddr_q <= reg_raddr_d;
            reg_re_q    <= reg_re_d;
            reg_waddr_q <= reg_waddr_d;
            reg_we_q    <= reg_we_d;
            reg_wdata_q <= reg_wdata_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign mem_addr   = mem_addr_q;
    assign mem_re     = mem_re_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign reg_raddr  = reg_raddr_q;
    assign reg_re     = reg_re_q;
    assign reg_waddr  = reg_waddr_q;
    assign reg_we     = reg_we_q;
    assign reg_wdata  = reg_wdata_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_mem_reg_xfer_ctrl.sv
// Bench for mem_reg_xfer_ctrl: cycle-exact sequences, a vector table, and a write scoreboard.
module tb_mem_reg_xfer_ctrl;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic          is_mem;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_wr_t;

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] ma;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [DW-1:0] d;
        int            lat;
        logic          is_mem;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_mem_addr, cmd_reg_src, cmd_reg_dst;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] mem_addr, reg_raddr, reg_waddr;
    logic          mem_re, mem_we, reg_re, reg_we, done, busy;
    logic [DW-1:0] mem_wdata, reg_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] reg_rdata = '0;
    logic [CW-1:0] xfer_count;

    logic          d2_ready, d2_mem_re, d2_mem_we, d2_reg_re, d2_reg_we, d2_done, d2_busy;
    logic [AW-1:0] d2_mem_addr, d2_reg_raddr, d2_reg_waddr;
    logic [DW-1:0] d2_mem_wdata, d2_reg_wdata;
    logic [1:0]    d2_count;

    mem_reg_xfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_mem_addr(cmd_mem_addr), .cmd_reg_src(cmd_reg_src), .cmd_reg_dst(cmd_reg_dst),
        .cmd_data(cmd_data), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .reg_raddr(reg_raddr), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .reg_waddr(reg_waddr), .reg_we(reg_we), .reg_wdata(reg_wdata),
        .done(done), .busy(busy), .xfer_count(xfer_count)
    );

    // Narrow-counter copy on the same inputs, used to reach saturation quickly.
    mem_reg_xfer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(d2_ready), .cmd_op(cmd_op),
        .cmd_mem_addr(cmd_mem_addr), .cmd_reg_src(cmd_reg_src), .cmd_reg_dst(cmd_reg_dst),
        .cmd_data(cmd_data), .mem_addr(d2_mem_addr), .mem_re(d2_mem_re), .mem_we(d2_mem_we),
        .mem_wdata(d2_mem_wdata), .mem_rdata(mem_rdata), .reg_raddr(d2_reg_raddr),
        .reg_re(d2_reg_re), .reg_rdata(reg_rdata), .reg_waddr(d2_reg_waddr), .reg_we(d2_reg_we),
        .reg_wdata(d2_reg_wdata), .done(d2_done), .busy(d2_busy), .xfer_count(d2_count)
    );

    logic [DW-1:0] mem_arr [1024];
    logic [DW-1:0] reg_arr [1024];
    logic [DW-1:0] gmem [1024];
    logic [DW-1:0] greg [1024];
    bit            loaded = 1'b0;

    int      checks = 0;
    int      errors = 0;
    int      exp_count = 0;
    exp_wr_t sb[$];
    exp_wr_t mon_e;
    vec_t    vecs[7];

    function automatic logic [DW-1:0] mem_init(int i);
        return (i == 'h3A) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
    endfunction

    function automatic logic [DW-1:0] reg_init(int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endfunction

    // Synchronous-read storage models: read data is valid the cycle after the strobe.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) begin
                mem_arr[i] <= mem_init(i);
                reg_arr[i] <= reg_init(i);
            end
            loaded <= 1'b1;
        end else begin
            if (mem_re) mem_rdata <= mem_arr[mem_addr];
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            if (reg_re) reg_rdata <= reg_arr[reg_raddr];
            if (reg_we) reg_arr[reg_waddr] <= reg_wdata;
        end
    end

    always @(negedge clk) begin
        if (!rst && (mem_re || mem_we)) check("mem_re_we_exclusive", {31'd0, mem_re & mem_we}, 0);
        if (!rst && (reg_we || mem_we)) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_is_mem", {31'd0, mem_we}, {31'd0, mon_e.is_mem});
                check("sb_addr", mem_we ? 32'(mem_addr) : 32'(reg_waddr), 32'(mon_e.addr));
                check("sb_data", mem_we ? mem_wdata : reg_wdata, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns 1ns after the accept edge, i.e. while the first post-accept cycle is visible.
    task automatic send(input logic [1:0] op, input logic [AW-1:0] ma, input logic [AW-1:0] src,
                        input logic [AW-1:0] dst, input logic [DW-1:0] d, input bit hold,
                        output time t_acc);
        exp_wr_t       e;
        logic [DW-1:0] v;
        int            n;
        cmd_op = op; cmd_mem_addr = ma; cmd_reg_src = src; cmd_reg_dst = dst; cmd_data = d;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 1, 0);
        @(posedge clk);
        t_acc = $time;
        #1;
        if (!hold) cmd_valid = 1'b0;
        case (op)
            2'b00: begin greg[dst] = d; e = '{1'b0, dst, d}; end
            2'b01: begin v = gmem[ma]; greg[dst] = v; e = '{1'b0, dst, v}; end
            2'b10: begin v = greg[src]; gmem[ma] = v; e = '{1'b1, ma, v}; end
            default: begin v = greg[src]; greg[dst] = v; e = '{1'b0, dst, v}; end
        endcase
        exp_count++;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time           t1, t2;
        int            k;
        logic [DW-1:0] saved;

        for (int i = 0; i < 1024; i++) begin
            gmem[i] = mem_init(i);
            greg[i] = reg_init(i);
        end
        cmd_valid = 0; cmd_op = 0; cmd_mem_addr = 0; cmd_reg_src = 0; cmd_reg_dst = 0;
        cmd_data = 0;

        #1 rst = 1'b1;
        repeat (3) tick();
        check("rst_mem_re", {31'd0, mem_re}, 0);
        check("rst_mem_we", {31'd0, mem_we}, 0);
        check("rst_reg_re", {31'd0, reg_re}, 0);
        check("rst_reg_we", {31'd0, reg_we}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_count", 32'(xfer_count), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_reg_wdata", reg_wdata, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, cmd_ready}, 1);

        // WRITEI dst=5
        send(2'b00, 0, 0, 5, 32'hDEAD_BEEF, 0, t1);
        check("wri_reg_we", {31'd0, reg_we}, 1);
        check("wri_waddr", 32'(reg_waddr), 5);
        check("wri_wdata", reg_wdata, 32'hDEAD_BEEF);
        check("wri_done", {31'd0, done}, 1);
        check("wri_count", 32'(xfer_count), 1);
        check("wri_ready_low", {31'd0, cmd_ready}, 0);
        tick();
        check("wri_ready_back", {31'd0, cmd_ready}, 1);
        check("wri_done_pulse", {31'd0, done}, 0);
        check("wri_we_drop", {31'd0, reg_we}, 0);

        // LOAD mem[0x3A] -> r7
        send(2'b01, 10'h3A, 0, 7, 0, 0, t1);
        check("ld_mem_re", {31'd0, mem_re}, 1);
        check("ld_mem_addr", 32'(mem_addr), 32'h3A);
        tick();
        check("ld_wait_re", {31'd0, mem_re}, 0);
        check("ld_wait_busy", {31'd0, busy}, 1);
        check("ld_wait_we", {31'd0, reg_we}, 0);
        tick();
        check("ld_reg_we", {31'd0, reg_we}, 1);
        check("ld_waddr", 32'(reg_waddr), 7);
        check("ld_wdata", reg_wdata, 32'h1234_5678);
        check("ld_done", {31'd0, done}, 1);
        tick();

        // STORE r7 -> mem[0x200]
        send(2'b10, 10'h200, 7, 0, 0, 0, t1);
        check("st_reg_re", {31'd0, reg_re}, 1);
        check("st_raddr", 32'(reg_raddr), 7);
        check("st_mem_re1", {31'd0, mem_re}, 0);
        tick();
        check("st_mem_re2", {31'd0, mem_re}, 0);
        tick();
        check("st_mem_we", {31'd0, mem_we}, 1);
        check("st_mem_addr", 32'(mem_addr), 32'h200);
        check("st_mem_wdata", mem_wdata, 32'h1234_5678);
        check("st_mem_re3", {31'd0, mem_re}, 0);
        tick();

        // Back-to-back MOVE 7->9, MOVE 9->9 with cmd_valid held
        send(2'b11, 0, 7, 9, 0, 1, t1);
        check("mv1_ready_low", {31'd0, cmd_ready}, 0);
        send(2'b11, 0, 9, 9, 0, 0, t2);
        check("mv_accept_gap", 32'(t2 - t1), 40);
        for (int c = 1; c <= 3; c++) begin
            check("mv2_ready_low", {31'd0, cmd_ready}, 0);
            tick();
        end
        check("mv2_ready_back", {31'd0, cmd_ready}, 1);
        check("mv_reg9", reg_arr[9], 32'h1234_5678);

        // Vector table
        vecs[0] = '{2'b00, 10'h000, 10'h000, 10'h003, 32'hCAFE_F00D, 1, 1'b0};
        vecs[1] = '{2'b11, 10'h000, 10'h003, 10'h004, 32'h0, 3, 1'b0};
        vecs[2] = '{2'b10, 10'h3FF, 10'h004, 10'h000, 32'h0, 3, 1'b1};
        vecs[3] = '{2'b01, 10'h3FF, 10'h000, 10'h3FF, 32'h0, 3, 1'b0};
        vecs[4] = '{2'b01, 10'h000, 10'h000, 10'h001, 32'h0, 3, 1'b0};
        vecs[5] = '{2'b10, 10'h001, 10'h3FF, 10'h000, 32'h0, 3, 1'b1};
        vecs[6] = '{2'b00, 10'h000, 10'h000, 10'h3FF, 32'h0, 1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].op, vecs[i].ma, vecs[i].src, vecs[i].dst, vecs[i].d, 0, t1);
            k = 1;
            while (!done && k < 8) begin
                tick();
                k++;
            end
            check("vec_latency", 32'(k), 32'(vecs[i].lat));
            check("vec_mem_we", {31'd0, mem_we}, {31'd0, vecs[i].is_mem});
            check("vec_count", 32'(xfer_count), 32'(exp_count));
            tick();
        end

        // Reset during the WAIT cycle of a LOAD: the write must never appear
        saved = greg[2];
        send(2'b01, 10'h3A, 0, 2, 0, 0, t1);
        void'(sb.pop_back());
        greg[2] = saved;
        tick();
        rst = 1'b1;
        #1;
        check("rstw_mem_re", {31'd0, mem_re}, 0);
        check("rstw_reg_re", {31'd0, reg_re}, 0);
        check("rstw_reg_we", {31'd0, reg_we}, 0);
        check("rstw_mem_we", {31'd0, mem_we}, 0);
        check("rstw_busy", {31'd0, busy}, 0);
        check("rstw_count", 32'(xfer_count), 0);
        repeat (2) tick();
        rst = 1'b0;
        exp_count = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rstw_no_we", {31'd0, reg_we}, 0);
        end
        check("rstw_reg2", reg_arr[2], greg[2]);
        check("rstw_count_after", 32'(xfer_count), 0);
        check("rstw_ready", {31'd0, cmd_ready}, 1);

        // Saturation on the 2-bit counter copy
        for (int i = 0; i < 5; i++) begin
            send(2'b00, 0, 0, 10'(20 + i), 32'(i), 0, t1);
            check("sat_count2", 32'(d2_count), (i + 1 > 3) ? 3 : 32'(i + 1));
            check("sat_count16", 32'(xfer_count), 32'(i + 1));
            tick();
        end
        repeat (2) tick();
        check("sat_hold", 32'(d2_count), 3);

        check("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_reg_xfer_ctrl.md
Name: mem_reg_xfer_ctrl

Overview:
- Command-driven sequencer that owns the data memory and register file ports of the datapath.
- Accepts one transfer command at a time over a valid/ready handshake and executes it as a fixed sequence of single-cycle read and write strobes:
  - immediate-to-register
  - memory-to-register (load)
  - register-to-memory (store)
  - register-to-register (move)
- Sits between the command source (test driver or future decode stage) and the memory/register-file storage.

Parameters:
- ADDR_W, 10, width of memory and register-file addresses
- DATA_W, 32, data word width
- CNT_W, 16, width of completed-transfer counter

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 WRITEI, 01 LOAD, 10 STORE, 11 MOVE
- cmd_mem_addr  input  ADDR_W  memory address (LOAD/STORE)
- cmd_reg_src  input  ADDR_W  source register (STORE/MOVE)
- cmd_reg_dst  input  ADDR_W  destination register (WRITEI/LOAD/MOVE)
- cmd_data  input  DATA_W  immediate (WRITEI)
- mem_addr  output  ADDR_W  memory address
- mem_re  output  1  memory read strobe
- mem_we  output  1  memory write strobe
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_re
- reg_raddr  output  ADDR_W  register-file read address
- reg_re  output  1  register-file read strobe
- reg_rdata  input  DATA_W  register read data, valid the cycle after reg_re
- reg_waddr  output  ADDR_W  register-file write address
- reg_we  output  1  register-file write strobe
- reg_wdata  output  DATA_W  register write data
- done  output  1  one-cycle pulse: command completed
- busy  output  1  high whenever state != IDLE
- xfer_count  output  CNT_W  completed commands, saturating

Behaviour:
- All outputs are registered.
- Reset (async, any time, including mid-command) values:
  - state = IDLE
  - all strobes, done and busy = 0
  - all addresses, data and xfer_count = 0
  - cmd_ready = 1 once rst deasserts
- A command in flight during reset is abandoned; no partial write may be issued after reset.
- FSM states: IDLE, READ, WAIT, WRITE.
- Handshake:
  - cmd_ready = 1 only in IDLE.
  - Accept on the rising edge where cmd_valid & cmd_ready.
  - All cmd_* fields latch at accept; later changes to inputs are ignored.
- IDLE:
  - on accept of WRITEI -> WRITE, with latched data = cmd_data
  - on accept of any other op -> READ
- READ (1 cycle):
  - LOAD: mem_re = 1, mem_addr = cmd_mem_addr.
  - STORE/MOVE: reg_re = 1, reg_raddr = cmd_reg_src.
  - -> WAIT.
- WAIT (1 cycle): capture mem_rdata (LOAD) or reg_rdata (STORE/MOVE) into the data latch. -> WRITE.
- WRITE (1 cycle):
  - WRITEI/LOAD/MOVE: reg_we = 1, reg_waddr = cmd_reg_dst, reg_wdata = latch.
  - STORE: mem_we = 1, mem_addr = cmd_mem_addr, mem_wdata = latch.
  - done = 1, xfer_count += 1 (holds at all-ones).
  - -> IDLE.
- Latency from accept edge T:
  - WRITEI: write strobe/done in cycle T+1, next accept possible at T+2.
  - LOAD/STORE/MOVE: read strobe T+1, capture T+2, write strobe/done T+3, next accept at T+4.
- Strobe rules:
  - Exactly one strobe per READ/WRITE cycle; strobes are never asserted in IDLE or WAIT.
  - mem_re and mem_we are never high together.
- Address and data outputs hold their last value when strobes are low.
- MOVE with src == dst is legal and rewrites the same value.
- Back-to-back commands: cmd_valid held high with a new command is accepted on the first IDLE edge; there are no bubbles beyond the fixed sequence.

Test Plan:
- Reset, then WRITEI dst=5 data=0xDEADBEEF -> reg_we=1 at T+1 with waddr=5, wdata=0xDEADBEEF; done pulse at T+1; xfer_count=1; cmd_ready back to 1 at T+2.
- Memory model preloaded mem[0x3A]=0x12345678; LOAD addr=0x3A dst=7 -> mem_re at T+1 addr 0x3A; reg_we at T+3 waddr=7, wdata=0x12345678.
- reg[7]=0x12345678; STORE src=7 addr=0x200 -> reg_re at T+1 raddr=7; mem_we at T+3 addr 0x200, wdata 0x12345678; mem_re stays 0 throughout.
- Back-to-back MOVE 7->9 then MOVE 9->9 with cmd_valid held -> second accept exactly 4 cycles after first; reg[9]=0x12345678; cmd_ready low during both sequences.
- Assert rst during WAIT of a LOAD -> all strobes 0 immediately; no reg_we ever issued; xfer_count=0; cmd_ready=1 after release.
- Force xfer_count to 0xFFFE and run 3 WRITEI -> count reads 0xFFFF and stays there.
